mprj_counter_array: RTL and testbench

MPRJ_COUNTER_ARRAY -- requirements
Module: mprj_counter_array

---
 rtl/mprj_counter_pkg.sv | 45 ++++
 rtl/mprj_counter_chan.sv | 110 +++++++++++
 rtl/mprj_counter_array.sv | 173 +++++++++++++++++
 tb/tb_mprj_counter_array.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_counter_pkg.sv
// mprj_counter_pkg -- shared constants for the counter-array user project.
//   Register map (per channel, stride 16 bytes inside a 256-byte window):
//     +0x0 CTRL   [0] EN, [1] DOWN, [2] AUTO, [3] IRQEN
//     +0x4 COUNT  live counter value
//     +0x8 RELOAD terminal value (up) / reload value (down)
//     +0xC STATUS [0] MATCH, write-1-to-clear
//   Also provides the pad-count default and a byte-lane mask helper.

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

package mprj_counter_pkg;

    localparam int WINDOW_BYTES = 256;
    localparam int CHAN_STRIDE  = 16;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_RELOAD = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    localparam int CTRL_W     = 4;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_DOWN  = 1;
    localparam int CTRL_AUTO  = 2;
    localparam int CTRL_IRQEN = 3;

    localparam int STATUS_MATCH = 0;

    // Channel c halt request lives on LA bit HALT_LA_BASE+c,
    // its match toggle on pad TOGGLE_IO_BASE+c.
    localparam int HALT_LA_BASE   = 64;
    localparam int TOGGLE_IO_BASE = 8;

    // Expand the four Wishbone byte selects into a per-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mprj_counter_chan.sv
// mprj_counter_chan -- one counter channel: CTRL/COUNT/RELOAD/STATUS
// registers, terminal-count detection, auto-reload and match toggle.
//   clk, rst_n        clock, asynchronous active-low reset
//   halt              freezes counting (register writes still apply)
//   *_we              one-cycle write strobes from the bus decoder
//   wdat, wmask       write data and per-bit byte-lane mask
//   ctrl/count/reload/match  register contents for readback
//   toggle            flips on every match-set event

module mprj_counter_chan
    import mprj_counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              ctrl_we,
    input  logic              count_we,
    input  logic              reload_we,
    input  logic              status_we,
    input  logic [WIDTH-1:0]  wdat,
    input  logic [WIDTH-1:0]  wmask,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  reload,
    output logic              match,
    output logic              toggle
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic              match_q, match_d;
    logic              toggle_q, toggle_d;

    logic run;
    logic count_up;
    logic terminal;

    assign count_up = ~ctrl_q[CTRL_DOWN];
    assign run      = ctrl_q[CTRL_EN] & ~halt;
    assign terminal = count_up ? (count_q == reload_q) : (count_q == '0);

    always_comb begin
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        reload_d = reload_q;
        match_d  = match_q;
        toggle_d = toggle_q;

        // Terminal cycle replaces the step: reload (AUTO) or stop in place.
        if (run) begin
            if (terminal) begin
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = count_up ? '0 : reload_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_up ? count_q + ONE : count_q - ONE;
            end
        end

        // Clear first so a coincident match set overrides it.
        if (status_we && wdat[STATUS_MATCH] && wmask[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
        if (run && terminal) begin
            match_d  = 1'b1;
            toggle_d = ~toggle_q;
        end

        // Bus writes are applied last so they win over counting.
        if (ctrl_we) begin
            ctrl_d = (ctrl_q & ~wmask[CTRL_W-1:0]) | (wdat[CTRL_W-1:0] & wmask[CTRL_W-1:0]);
        end
        if (count_we) begin
            count_d = (count_q & ~wmask) | (wdat & wmask);
        end
        if (reload_we) begin
            reload_d = (reload_q & ~wmask) | (wdat & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            reload_q <= '0;
            match_q  <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            match_q  <= match_d;
            toggle_q <= toggle_d;
        end
    end

    assign ctrl   = ctrl_q;
    assign count  = count_q;
    assign reload = reload_q;
    assign match  = match_q;
    assign toggle = toggle_q;

endmodule

// File: rtl/mprj_counter_array.sv
// mprj_counter_array -- Wishbone-mapped array of NCH up/down counters.
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   wbs_*                   Wishbone classic slave port (byte addresses)
//   la_data_in/la_oen       LA inputs; bit 64+c halts channel c when driven 1
//   la_data_out             packed COUNT values of all channels
//   io_in/io_out/io_oeb     pads; io_out[8+c] is channel c match toggle
//   irq                     registered OR of enabled MATCH flags
//
// Handshake: a transfer is accepted in a cycle where cyc&stb hits the
// window and no ack is currently high; the write takes effect and read data
// is registered at that edge, and ack is high for exactly the next cycle.
// Because acceptance is blocked while ack is high, a master holding stb
// sees acks separated by at least one idle cycle.

module mprj_counter_array
    import mprj_counter_pkg::*;
#(
    parameter int          NCH      = 2,
    parameter int          WIDTH    = 32,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    input  logic [127:0]              la_data_in,
    input  logic [127:0]              la_oen,
    output logic [127:0]              la_data_out,
    input  logic [`MPRJ_IO_PADS-1:0]  io_in,
    output logic [`MPRJ_IO_PADS-1:0]  io_out,
    output logic [`MPRJ_IO_PADS-1:0]  io_oeb,
    output logic                      irq
);

    generate
        if (NCH < 1 || NCH > 8 || WIDTH < 8 || WIDTH > 32 || NCH * WIDTH > 64) begin : g_param_err
            $error("mprj_counter_array: illegal parameters NCH=%0d WIDTH=%0d", NCH, WIDTH);
        end
    endgenerate

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic        accept;
    logic [3:0]  acc_ch;
    logic [3:0]  acc_ofs;
    logic [31:0] wmask;
    logic [31:0] rdata;

    logic [NCH-1:0] ctrl_we, count_we, reload_we, status_we, halt;

    logic [CTRL_W-1:0] ch_ctrl   [NCH];
    logic [WIDTH-1:0]  ch_count  [NCH];
    logic [WIDTH-1:0]  ch_reload [NCH];
    logic [NCH-1:0]    ch_match;
    logic [NCH-1:0]    ch_toggle;

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign accept  = hit & ~ack_q;
    assign acc_ch  = wbs_adr_i[7:4];
    assign acc_ofs = {wbs_adr_i[3:2], 2'b00};
    assign wmask   = byte_mask(wbs_sel_i);

    // Write strobes and halt decode. Channels >= NCH never match acc_ch, so
    // writes there are acked but dropped.
    always_comb begin
        ctrl_we   = '0;
        count_we  = '0;
        reload_we = '0;
        status_we = '0;
        halt      = '0;
        for (int c = 0; c < NCH; c++) begin
            if (accept && wbs_we_i && acc_ch == 4'(c)) begin
                case (acc_ofs)
                    OFS_CTRL:   ctrl_we[c]   = 1'b1;
                    OFS_COUNT:  count_we[c]  = 1'b1;
                    OFS_RELOAD: reload_we[c] = 1'b1;
                    OFS_STATUS: status_we[c] = 1'b1;
                    default: ;
                endcase
            end
            halt[c] = ~la_oen[HALT_LA_BASE + c] & la_data_in[HALT_LA_BASE + c];
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            mprj_counter_chan #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk       (wb_clk_i),
                .rst_n     (wb_rst_ni),
                .halt      (halt[c]),
                .ctrl_we   (ctrl_we[c]),
                .count_we  (count_we[c]),
                .reload_we (reload_we[c]),
                .status_we (status_we[c]),
                .wdat      (wbs_dat_i[WIDTH-1:0]),
                .wmask     (wmask[WIDTH-1:0]),
                .ctrl      (ch_ctrl[c]),
                .count     (ch_count[c]),
                .reload    (ch_reload[c]),
                .match     (ch_match[c]),
                .toggle    (ch_toggle[c])
            );
        end
    endgenerate

    // Read mux; anything unmapped reads as zero.
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NCH; c++) begin
            if (acc_ch == 4'(c)) begin
                case (acc_ofs)
                    OFS_CTRL:   rdata = 32'(ch_ctrl[c]);
                    OFS_COUNT:  rdata = 32'(ch_count[c]);
                    OFS_RELOAD: rdata = 32'(ch_reload[c]);
                    OFS_STATUS: rdata = 32'(ch_match[c]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        ack_d = accept;
        dat_d = (accept && !wbs_we_i) ? rdata : '0;
        irq_d = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            irq_d = irq_d | (ch_match[c] & ch_ctrl[c][CTRL_IRQEN]);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            irq_q <= irq_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

    always_comb begin
        la_data_out = '0;
        io_out      = '0;
        io_oeb      = '1;
        for (int c = 0; c < NCH; c++) begin
            la_data_out[c*WIDTH +: WIDTH] = ch_count[c];
            io_out[TOGGLE_IO_BASE + c]    = ch_toggle[c];
            io_oeb[TOGGLE_IO_BASE + c]    = 1'b0;
        end
    end

    // Inputs (or input bits) that carry no function in this design.
    logic unused_bits;
    assign unused_bits = ^{io_in, la_data_in, la_oen, wbs_dat_i, wmask, wbs_adr_i[1:0]};

endmodule

// File: tb/tb_mprj_counter_array.sv
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_mprj_counter_array;

    localparam int PADS = `MPRJ_IO_PADS;

    localparam logic [31:0] A_CTRL0   = 32'h3000_0000;
    localparam logic [31:0] A_COUNT0  = 32'h3000_0004;
    localparam logic [31:0] A_RELOAD0 = 32'h3000_0008;
    localparam logic [31:0] A_STATUS0 = 32'h3000_000C;
    localparam logic [31:0] A_CTRL1   = 32'h3000_0010;
    localparam logic [31:0] A_COUNT1  = 32'h3000_0014;
    localparam logic [31:0] A_RELOAD1 = 32'h3000_0018;
    localparam logic [31:0] A_STATUS1 = 32'h3000_001C;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     dat_o;
    logic [127:0]    la_in, la_oen, la_out;
    logic [PADS-1:0] io_in, io_out, io_oeb;
    logic            irq;

    mprj_counter_array dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_in  (la_in),
        .la_oen      (la_oen),
        .la_data_out (la_out),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output logic acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd    = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        ok;
        wb_cycle(1'b1, a, d, s, rd, ok);
        check("write_ack", 128'(ok), 128'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ok;
        wb_cycle(1'b0, a, 32'd0, 4'hF, rd, ok);
        check({tag, "_ack"}, 128'(ok), 128'd1);
        check(tag, 128'(rd), 128'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0]     rd;
        logic            ok;
        logic [PADS-1:0] oeb_exp;

        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        la_in = '0; la_oen = '1; io_in = '0;
        oeb_exp = '1;
        oeb_exp[9:8] = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 128'(ack), 128'd0);
        check("rst_dat", 128'(dat_o), 128'd0);
        check("rst_irq", 128'(irq), 128'd0);
        check("rst_la", la_out, 128'd0);
        check("rst_io_out", 128'(io_out), 128'd0);
        check("rst_io_oeb", 128'(io_oeb), 128'(oeb_exp));
        @(negedge clk);
        rst_n = 1'b1;
        wb_read(A_CTRL0,   "rst_ctrl0", 0);
        wb_read(A_COUNT0,  "rst_count0", 0);
        wb_read(A_RELOAD0, "rst_reload0", 0);
        wb_read(A_STATUS0, "rst_status0", 0);
        wb_read(A_CTRL1,   "rst_ctrl1", 0);
        wb_read(A_COUNT1,  "rst_count1", 0);
        wb_read(A_RELOAD1, "rst_reload1", 0);
        wb_read(A_STATUS1, "rst_status1", 0);

        // Auto-reload up counter: 0..5,0..5,...; toggle flips at each wrap
        wb_write(A_RELOAD0, 32'd5, 4'hF);
        wb_write(A_CTRL0,   32'h5, 4'hF);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("up_count", 128'(la_out[31:0]), 128'(i % 6));
            check("up_toggle", 128'(io_out[8]), 128'((i / 6) % 2));
        end

        // Halt via LA bit 64: count is 1 here, freezes, resumes at 2
        la_oen[64] = 1'b0;
        la_in[64]  = 1'b1;
        check("halt_capture", 128'(la_out[31:0]), 128'd1);
        repeat (5) begin
            @(posedge clk); #1;
            check("halt_hold", 128'(la_out[31:0]), 128'd1);
        end
        wb_read(A_CTRL0, "halt_ctrl_read", 32'h5);
        check("halt_hold_after_read", 128'(la_out[31:0]), 128'd1);
        la_in[64]  = 1'b0;
        la_oen[64] = 1'b1;
        @(posedge clk); #1;
        check("halt_resume", 128'(la_out[31:0]), 128'd2);

        // Stop channel 0, MATCH set from wraps, then write-1-to-clear
        wb_write(A_CTRL0, 32'h0, 4'hF);
        wb_read(A_STATUS0, "status0_set", 1);
        wb_write(A_STATUS0, 32'h1, 4'hF);
        wb_read(A_STATUS0, "status0_w1c", 0);

        // One-shot down counter on channel 1: 3,2,1,0 then hold
        wb_write(A_COUNT1, 32'd3, 4'hF);
        wb_write(A_CTRL1,  32'h3, 4'hF);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            check("down_count", 128'(la_out[63:32]), 128'((i <= 3) ? 3 - i : 0));
        end
        wb_read(A_CTRL1, "down_en_cleared", 32'h2);
        wb_read(A_STATUS1, "down_match", 1);
        check("down_toggle", 128'(io_out[9]), 128'd1);

        // irq follows MATCH & IRQEN through one register stage
        wb_write(A_CTRL1, 32'h8, 4'hF);
        check("irq_pre", 128'(irq), 128'd0);
        @(posedge clk); #1;
        check("irq_set", 128'(irq), 128'd1);
        wb_write(A_STATUS1, 32'h1, 4'hF);
        check("irq_still_set", 128'(irq), 128'd1);
        @(posedge clk); #1;
        check("irq_clear", 128'(irq), 128'd0);

        // W1C landing on the same edge as a match: MATCH stays set
        wb_write(A_COUNT0, 32'd0, 4'hF);
        wb_write(A_CTRL0,  32'h5, 4'hF);
        repeat (5) @(posedge clk);
        wb_write(A_STATUS0, 32'h1, 4'hF);
        check("coinc_wrap", 128'(la_out[31:0]), 128'd0);
        wb_read(A_STATUS0, "coinc_match_wins", 1);
        wb_write(A_CTRL0, 32'h0, 4'hF);

        // Byte lanes and reserved CTRL bits
        wb_write(A_RELOAD1, 32'hAABB_CCDD, 4'b0101);
        wb_read(A_RELOAD1, "sel_lo", 32'h00BB_00DD);
        wb_write(A_RELOAD1, 32'h1122_3344, 4'b1010);
        wb_read(A_RELOAD1, "sel_hi", 32'h11BB_33DD);
        wb_write(A_CTRL1, 32'hFFFF_FFF8, 4'hF);
        wb_read(A_CTRL1, "ctrl_reserved", 32'h8);

        // Unmapped channel acks with 0; outside the window never acks
        wb_cycle(1'b0, 32'h3000_00F0, 32'd0, 4'hF, rd, ok);
        check("unmapped_ack", 128'(ok), 128'd1);
        check("unmapped_data", 128'(rd), 128'd0);
        wb_cycle(1'b0, 32'h3000_0100, 32'd0, 4'hF, rd, ok);
        check("outside_no_ack", 128'(ok), 128'd0);

        // Held strobe: ack alternates, data valid only with ack
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RELOAD0; sel = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check("b2b_ack", 128'(ack), 128'(k % 2));
            check("b2b_data", 128'(dat_o), 128'((k % 2 == 1) ? 5 : 0));
        end
        cyc = 1'b0; stb = 1'b0;

        // Reset during an acked read
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_RELOAD0;
        @(posedge clk); #1;
        check("rst_mid_pre_ack", 128'(ack), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 128'(ack), 128'd0);
        check("rst_mid_dat", 128'(dat_o), 128'd0);
        check("rst_mid_la", la_out, 128'd0);
        check("rst_mid_io_out", 128'(io_out), 128'd0);
        check("rst_mid_io_oeb", 128'(io_oeb), 128'(oeb_exp));
        check("rst_mid_irq", 128'(irq), 128'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("rst_no_late_ack", 128'(ack), 128'd0);
        end
        wb_read(A_RELOAD0, "post_rst_reload0", 0);
        wb_read(A_CTRL1,   "post_rst_ctrl1", 0);
        wb_read(A_STATUS0, "post_rst_status0", 0);
        wb_read(A_RELOAD1, "post_rst_reload1", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
